// File: rtl/bcd_countdown_timer_if.sv
// Keypad/control side bundle of the BCD countdown timer: command inputs plus display/status outputs.
interface bcd_countdown_timer_if #(
  parameter int DIGITS = 4
);
  logic [3:0]          input_signal;
  logic                load;
  logic                start;
  logic                stop;
  logic                clear;
  logic                en;
  logic [4*DIGITS-1:0] count;
  logic                running;
  logic                zero;
  logic                done;

  modport master (
    output input_signal, load, start, stop, clear, en,
    input  count, running, zero, done
  );

  modport slave (
    input  input_signal, load, start, stop, clear, en,
    output count, running, zero, done
  );
endinterface

// File: rtl/bcd_countdown_timer.sv
// DIGITS-wide BCD countdown timer with keypad entry, start/stop/resume and optional MM:SS borrow.
// Optional tick prescaler selected by macro TIMER_PRESCALER_EN.
module bcd_countdown_timer #(
  parameter int DIGITS = 4,
  parameter int MMSS   = 1
`ifdef TIMER_PRESCALER_EN
  , parameter int PRESCALE = 100
`endif
) (
  input logic                clk,
  input logic                clear_n,
  bcd_countdown_timer_if.slave bus
);

  localparam int CW = 4 * DIGITS;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // One BCD decrement with borrow; tens-of-seconds wraps to 5 in MM:SS mode.
  function automatic logic [CW-1:0] bcd_dec(input logic [CW-1:0] value);
    logic [CW-1:0] res;
    logic          borrow;
    logic [3:0]    d;
    res    = value;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      d = value[4*i +: 4];
      if (borrow) begin
        if (d == 4'd0) begin
          res[4*i +: 4] = ((MMSS != 0) && (i == 1)) ? 4'd5 : 4'd9;
        end else begin
          res[4*i +: 4] = d - 4'd1;
          borrow        = 1'b0;
        end
      end else begin
        res[4*i +: 4] = d;
      end
    end
    return res;
  endfunction

  state_t        state_r, state_s;
  logic [CW-1:0] count_r, count_s;
  logic          running_r, running_s;
  logic          done_r, done_s;
  logic [CW-1:0] dec_s;
  logic [CW-1:0] shift_s;
  logic          load_ok_s;
  logic          nonzero_s;
  logic          tick_s;

  assign dec_s     = bcd_dec(count_r);
  assign shift_s   = {count_r[CW-5:0], bus.input_signal};
  assign load_ok_s = bus.load && (bus.input_signal <= 4'd9);
  assign nonzero_s = (count_r != {CW{1'b0}});

`ifdef TIMER_PRESCALER_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] presc_r, presc_s;

  assign tick_s = bus.en && (presc_r == PW'(PRESCALE - 1));

  // Prescaler next value: restart on clear, start-from-idle and stop; hold while paused.
  always_comb begin
    presc_s = presc_r;
    if (bus.clear) begin
      presc_s = {PW{1'b0}};
    end else if ((state_r == ST_IDLE) && (state_s == ST_RUN)) begin
      presc_s = {PW{1'b0}};
    end else if ((state_r == ST_RUN) && bus.stop) begin
      presc_s = {PW{1'b0}};
    end else if ((state_r == ST_RUN) && bus.en) begin
      presc_s = tick_s ? {PW{1'b0}} : presc_r + PW'(1);
    end else begin
      presc_s = presc_r;
    end
  end

  // Prescaler register.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      presc_r <= {PW{1'b0}};
    end else begin
      presc_r <= presc_s;
    end
  end
`else
  assign tick_s = bus.en;
`endif

  // State and count register with registered status outputs.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_r   <= ST_IDLE;
      count_r   <= {CW{1'b0}};
      running_r <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      count_r   <= count_s;
      running_r <= running_s;
      done_r    <= done_s;
    end
  end

  // Next state and count; clear beats stop beats start beats load beats en.
  always_comb begin
    state_s = state_r;
    count_s = count_r;
    if (bus.clear) begin
      state_s = ST_IDLE;
      count_s = {CW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.start && nonzero_s) begin
            state_s = ST_RUN;
          end else if (load_ok_s) begin
            count_s = shift_s;
          end else begin
            count_s = count_r;
          end
        end
        ST_RUN: begin
          if (bus.stop) begin
            state_s = ST_PAUSED;
          end else if (tick_s) begin
            count_s = dec_s;
            state_s = (dec_s == {CW{1'b0}}) ? ST_DONE : ST_RUN;
          end else begin
            state_s = ST_RUN;
          end
        end
        ST_PAUSED: begin
          if (bus.start) begin
            state_s = ST_RUN;
          end else begin
            state_s = ST_PAUSED;
          end
        end
        ST_DONE: begin
          if (load_ok_s) begin
            count_s = shift_s;
            state_s = ST_IDLE;
          end else begin
            state_s = ST_DONE;
          end
        end
        default: begin
          state_s = ST_IDLE;
          count_s = {CW{1'b0}};
        end
      endcase
    end
  end

  // Status outputs for the coming cycle; done pulses only on the RUN->DONE edge.
  always_comb begin
    running_s = (state_s == ST_RUN);
    done_s    = (state_r == ST_RUN) && (state_s == ST_DONE);
  end

  assign bus.count   = count_r;
  assign bus.running = running_r;
  assign bus.done    = done_r;
  assign bus.zero    = (count_r == {CW{1'b0}});

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed plus randomized check of bcd_countdown_timer (DIGITS=4, MMSS=1) against a digit-array model.
module tb_bcd_countdown_timer;

  localparam int DIGITS = 4;
  localparam int CW     = 4 * DIGITS;

  logic clk = 1'b0;
  logic clear_n;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  bcd_countdown_timer_if #(.DIGITS(DIGITS)) bus ();

  bcd_countdown_timer #(.DIGITS(DIGITS), .MMSS(1)) dut (
    .clk     (clk),
    .clear_n (clear_n),
    .bus     (bus)
  );

  // Reference model: digits as integers, state as a small code.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;
  int   m_dig[DIGITS];
  int   m_st;
  logic m_done;

  function automatic logic [CW-1:0] m_count();
    logic [CW-1:0] v;
    for (int i = 0; i < DIGITS; i++) v[4*i +: 4] = 4'(m_dig[i]);
    return v;
  endfunction

  function automatic bit m_is_zero();
    for (int i = 0; i < DIGITS; i++) if (m_dig[i] != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < DIGITS; i++) m_dig[i] = 0;
    m_st   = M_IDLE;
    m_done = 1'b0;
  endtask

  task automatic m_shift(input int d);
    for (int i = DIGITS - 1; i > 0; i--) m_dig[i] = m_dig[i-1];
    m_dig[0] = d;
  endtask

  // Take one off the lowest nonzero digit; every digit below it becomes its maximum.
  task automatic m_decrement();
    int k;
    k = 0;
    while (k < DIGITS && m_dig[k] == 0) k++;
    if (k < DIGITS) begin
      m_dig[k] = m_dig[k] - 1;
      for (int j = 0; j < k; j++) m_dig[j] = (j == 1) ? 5 : 9;
    end
  endtask

  task automatic model_step();
    bit valid;
    valid  = bus.load && (bus.input_signal <= 4'd9);
    m_done = 1'b0;
    if (bus.clear) begin
      for (int i = 0; i < DIGITS; i++) m_dig[i] = 0;
      m_st = M_IDLE;
    end else if (m_st == M_IDLE) begin
      if (bus.start && !m_is_zero()) m_st = M_RUN;
      else if (valid) m_shift(int'(bus.input_signal));
    end else if (m_st == M_RUN) begin
      if (bus.stop) m_st = M_PAUSED;
      else if (bus.en) begin
        m_decrement();
        if (m_is_zero()) begin
          m_st   = M_DONE;
          m_done = 1'b1;
        end
      end
    end else if (m_st == M_PAUSED) begin
      if (bus.start) m_st = M_RUN;
    end else begin
      if (valid) begin
        m_shift(int'(bus.input_signal));
        m_st = M_IDLE;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, ".count"},   32'(bus.count),   32'(m_count()));
    chk({tag, ".running"}, 32'(bus.running), 32'(m_st == M_RUN));
    chk({tag, ".zero"},    32'(bus.zero),    32'(m_is_zero()));
    chk({tag, ".done"},    32'(bus.done),    32'(m_done));
  endtask

  task automatic step(input logic ld, input logic [3:0] d, input logic st, input logic sp,
                      input logic cl, input logic e);
    bus.load = ld; bus.input_signal = d; bus.start = st;
    bus.stop = sp; bus.clear = cl; bus.en = e;
    model_step();
    @(posedge clk);
    #1;
    cmp_model("cyc");
  endtask

  task automatic do_clear();              step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0); endtask
  task automatic do_load(input logic [3:0] d); step(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0); endtask
  task automatic do_start();              step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0); endtask
  task automatic do_en();                 step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1); endtask

  initial begin
    clear_n = 1'b0;
    bus.load = 1'b0; bus.input_signal = 4'd0; bus.start = 1'b0;
    bus.stop = 1'b0; bus.clear = 1'b0; bus.en = 1'b0;
    m_reset();
    #12;
    chk("rst.count",   32'(bus.count),   32'h0);
    chk("rst.zero",    32'(bus.zero),    32'h1);
    chk("rst.running", 32'(bus.running), 32'h0);
    chk("rst.done",    32'(bus.done),    32'h0);
    @(negedge clk);
    clear_n = 1'b1;

    do_load(4'd1); do_load(4'd3); do_load(4'd0);
    chk("load130", 32'(bus.count), 32'h0130);
    chk("load130.zero", 32'(bus.zero), 32'h0);
    chk("load130.running", 32'(bus.running), 32'h0);

    do_clear(); do_load(4'd1); do_load(4'd0); do_load(4'd0);
    do_start();
    chk("start.running", 32'(bus.running), 32'h1);
    do_en();
    chk("dec0100", 32'(bus.count), 32'h0059);
    do_en();
    chk("dec0059", 32'(bus.count), 32'h0058);

    do_clear(); do_load(4'd2); do_start();
    do_en();
    chk("dec0002", 32'(bus.count), 32'h0001);
    do_en();
    chk("end.count", 32'(bus.count), 32'h0000);
    chk("end.done", 32'(bus.done), 32'h1);
    chk("end.running", 32'(bus.running), 32'h0);
    do_en();
    chk("after.done", 32'(bus.done), 32'h0);
    chk("after.count", 32'(bus.count), 32'h0000);

    do_clear(); do_load(4'd1); do_load(4'd0); do_start();
    step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("stop.count", 32'(bus.count), 32'h0010);
    chk("stop.running", 32'(bus.running), 32'h0);
    for (int i = 0; i < 5; i++) do_en();
    chk("paused.count", 32'(bus.count), 32'h0010);
    do_start();
    chk("resume.running", 32'(bus.running), 32'h1);
    do_en();
    chk("dec0010", 32'(bus.count), 32'h0009);

    do_clear(); do_load(4'd1); do_load(4'hC);
    chk("load_bad", 32'(bus.count), 32'h0001);
    do_start(); do_load(4'd5);
    chk("load_run", 32'(bus.count), 32'h0001);
    do_clear(); do_start();
    chk("start_zero", 32'(bus.running), 32'h0);

    do_clear(); do_load(4'd9); do_load(4'd0); do_start(); do_en();
    chk("dec0090", 32'(bus.count), 32'h0089);

    do_clear(); do_load(4'd4); do_load(4'd2); do_start();
    chk("pre_async", 32'(bus.count), 32'h0042);
    clear_n = 1'b0;
    #2;
    chk("async.count", 32'(bus.count), 32'h0);
    chk("async.zero", 32'(bus.zero), 32'h1);
    chk("async.running", 32'(bus.running), 32'h0);
    m_reset();
    @(negedge clk);
    clear_n = 1'b1;

    do_load(4'd1); do_start(); do_en();
    chk("done2", 32'(bus.done), 32'h1);
    do_clear();
    chk("clr_done.done", 32'(bus.done), 32'h0);
    chk("clr_done.count", 32'(bus.count), 32'h0);

    // Random phase: short entries and frequent clears so runs reach DONE.
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)),
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 39) == 0), ($urandom_range(0, 1) == 1));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
